// File: rtl/symbol_pingpong_buffer_pkg.sv
// rtl/symbol_pingpong_buffer_pkg.sv - shared OFDM symbol constants and index helpers
package symbol_pingpong_buffer_pkg;

   localparam int SYM_N_SUB = 64;
   localparam int SYM_IDX_W = $clog2(SYM_N_SUB);

   // Reverses the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
      logic [31:0] r;
      logic [31:0] t;
      r = '0;
      t = v;
      for (int i = 0; i < 32; i++) begin
         if (i < w) begin
            r = {r[30:0], t[0]};
            t = t >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sym_bank_ram.sv
// rtl/sym_bank_ram.sv - one symbol bank: register array, single write port, async read
module sym_bank_ram #(
   parameter int DATA_W = 8,
   parameter int N_SUB  = 64,
   localparam int AW    = $clog2(N_SUB)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [2*DATA_W-1:0] wdata,
   input  logic [AW-1:0]       raddr,
   output logic [2*DATA_W-1:0] rdata
);

   logic [2*DATA_W-1:0] mem [N_SUB];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/symbol_pingpong_buffer.sv
// rtl/symbol_pingpong_buffer.sv - two-bank OFDM symbol ping-pong buffer with index checker
module symbol_pingpong_buffer
   import symbol_pingpong_buffer_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int N_SUB       = SYM_N_SUB,
   parameter int BIT_REVERSE = 0,
   parameter int CHECK_SEQ   = 1,
   localparam int IDX_W      = $clog2(N_SUB)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              err_seq,
   output logic [7:0]        err_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SUB - 1);

   logic [1:0]          full;
   logic                wr_sel;
   logic                rd_sel;
   logic [IDX_W-1:0]    wr_ptr;
   logic [IDX_W-1:0]    rd_ptr;
   logic                wr_fire;
   logic                wr_last;
   logic                rd_fire;
   logic                rd_last;
   logic [2*DATA_W-1:0] bank_rdata [2];
   logic [2*DATA_W-1:0] rd_word;

   assign in_ready  = !full[wr_sel];
   assign out_valid = full[rd_sel];
   assign wr_fire   = in_valid && in_ready;
   assign wr_last   = wr_fire && (wr_ptr == LAST_IDX);
   assign rd_fire   = out_valid && out_ready;
   assign out_last  = out_valid && (rd_ptr == LAST_IDX);
   assign rd_last   = rd_fire && (rd_ptr == LAST_IDX);

   // A bank being filled is never full and the bank being drained always is,
   // so the set and the clear below can never land on the same bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full   <= 2'b00;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
         if (wr_last) begin
            full[wr_sel] <= 1'b1;
            wr_sel       <= ~wr_sel;
         end
         if (rd_last) begin
            full[rd_sel] <= 1'b0;
            rd_sel       <= ~rd_sel;
         end
      end
   end

   generate
      if (BIT_REVERSE != 0) begin : g_idx_rev
         assign out_idx = IDX_W'(bit_rev(32'(rd_ptr), IDX_W));
      end else begin : g_idx_lin
         assign out_idx = rd_ptr;
      end
   endgenerate

   for (genvar b = 0; b < 2; b++) begin : g_bank
      sym_bank_ram #(
         .DATA_W(DATA_W),
         .N_SUB (N_SUB)
      ) u_ram (
         .clk  (clk),
         .we   (wr_fire && (wr_sel == 1'(b))),
         .waddr(wr_ptr),
         .wdata({in_re, in_im}),
         .raddr(out_idx),
         .rdata(bank_rdata[b])
      );
   end

   assign rd_word = bank_rdata[rd_sel];
   assign out_re  = rd_word[2*DATA_W-1:DATA_W];
   assign out_im  = rd_word[DATA_W-1:0];

   generate
      if (CHECK_SEQ != 0) begin : g_check
         logic [IDX_W-1:0] exp_im;
         logic             seq_bad;

         // Expected test pattern: re counts up with the slot, im counts down.
         assign exp_im  = LAST_IDX - wr_ptr;
         assign seq_bad = (in_re != DATA_W'(wr_ptr)) || (in_im != DATA_W'(exp_im));

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               err_seq <= 1'b0;
               err_cnt <= 8'd0;
            end else begin
               err_seq <= wr_fire && seq_bad;
               if (wr_fire && seq_bad && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            end
         end
      end else begin : g_no_check
         assign err_seq = 1'b0;
         assign err_cnt = 8'd0;
      end
   endgenerate

endmodule

// File: tb/tb_symbol_pingpong_buffer.sv
// tb/tb_symbol_pingpong_buffer.sv - self-checking bench for symbol_pingpong_buffer
module tb_symbol_pingpong_buffer;

   localparam int DW = 8;
   localparam int N  = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_re = '0;
   logic [DW-1:0] in_im = '0;
   logic          out_ready = 1'b1;

   logic          in_ready_n, out_valid_n, out_last_n, err_seq_n;
   logic [DW-1:0] out_re_n, out_im_n;
   logic [5:0]    out_idx_n;
   logic [7:0]    err_cnt_n;

   logic          in_ready_r, out_valid_r, out_last_r, err_seq_r;
   logic [DW-1:0] out_re_r, out_im_r;
   logic [5:0]    out_idx_r;
   logic [7:0]    err_cnt_r;

   always #5 clk = ~clk;

   symbol_pingpong_buffer #(.DATA_W(DW), .N_SUB(N), .BIT_REVERSE(0), .CHECK_SEQ(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready_n), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid_n), .out_ready(out_ready), .out_re(out_re_n), .out_im(out_im_n),
      .out_idx(out_idx_n), .out_last(out_last_n), .err_seq(err_seq_n), .err_cnt(err_cnt_n)
   );

   symbol_pingpong_buffer #(.DATA_W(DW), .N_SUB(N), .BIT_REVERSE(1), .CHECK_SEQ(1)) dut_br (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready_r), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid_r), .out_ready(out_ready), .out_re(out_re_r), .out_im(out_im_r),
      .out_idx(out_idx_r), .out_last(out_last_r), .err_seq(err_seq_r), .err_cnt(err_cnt_r)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int brev6(input int v);
      int r = 0;
      for (int i = 0; i < 6; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   // Model: completed symbols as a flat sample queue, partial symbol separately.
   logic [15:0] done_q[$];
   logic [15:0] part[$];
   int          rp = 0;
   bit          err_pend = 0;
   int          err_m = 0;

   int          n_out = 0, n_last = 0, n_pulse = 0, n_rdy_low = 0;
   logic [5:0]  br_log[$];
   logic [5:0]  idx_log[$];
   logic [7:0]  re_log[$];
   logic [7:0]  cap_re[N];

   always @(negedge clk) begin
      bit exp_rdy, exp_vld, wr, rd;
      int idx_b;
      logic [15:0] w;
      if (!reset) begin
         done_q.delete();
         part.delete();
         rp = 0;
         err_pend = 0;
         err_m = 0;
      end else begin
         exp_rdy = done_q.size() < 2 * N;
         exp_vld = done_q.size() >= N;
         chk("in_ready", in_ready_n, exp_rdy);
         chk("in_ready_br", in_ready_r, exp_rdy);
         chk("out_valid", out_valid_n, exp_vld);
         chk("out_valid_br", out_valid_r, exp_vld);
         chk("err_seq", err_seq_n, err_pend);
         chk("err_cnt", err_cnt_n, err_m);
         chk("err_cnt_br", err_cnt_r, err_m);
         if (exp_vld) begin
            w = done_q[rp];
            chk("out_idx", out_idx_n, rp);
            chk("out_re", out_re_n, w[15:8]);
            chk("out_im", out_im_n, w[7:0]);
            chk("out_last", out_last_n, rp == N - 1);
            idx_b = brev6(rp);
            w = done_q[idx_b];
            chk("out_idx_br", out_idx_r, idx_b);
            chk("out_re_br", out_re_r, w[15:8]);
            chk("out_last_br", out_last_r, rp == N - 1);
         end
         if (out_valid_n && out_ready) begin
            n_out++;
            if (out_last_n) n_last++;
            cap_re[out_idx_n] = out_re_n;
            idx_log.push_back(out_idx_n);
            re_log.push_back(out_re_n);
         end
         if (out_valid_r && out_ready) br_log.push_back(out_idx_r);
         if (err_seq_n) n_pulse++;
         if (!in_ready_n) n_rdy_low++;

         wr = in_valid && exp_rdy;
         rd = exp_vld && out_ready;
         err_pend = 0;
         if (rd) begin
            if (rp == N - 1) begin
               repeat (N) void'(done_q.pop_front());
               rp = 0;
            end else rp++;
         end
         if (wr) begin
            if (int'(in_re) != part.size() || int'(in_im) != N - 1 - part.size()) begin
               err_pend = 1;
               if (err_m < 255) err_m++;
            end
            part.push_back({in_re, in_im});
            if (part.size() == N) begin
               foreach (part[i]) done_q.push_back(part[i]);
               part.delete();
            end
         end
      end
   end

   task automatic send(input int re, input int im);
      bit acc = 0;
      int t = 0;
      in_valid = 1'b1;
      in_re = 8'(re);
      in_im = 8'(im);
      while (!acc && t < 2000) begin
         @(negedge clk);
         acc = in_ready_n;
         t++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_sym(input int bad_idx, input int bad_re);
      for (int i = 0; i < N; i++) send((i == bad_idx) ? bad_re : i, N - 1 - i);
   endtask

   task automatic wait_drain();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((done_q.size() != 0 || out_valid_n) && t < 1000);
      if (t >= 1000) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int s_out, s_last, s_pulse, s_low, s_br, s_idx;

      #2;
      chk("rst_in_ready", in_ready_n, 1);
      chk("rst_out_valid", out_valid_n, 0);
      chk("rst_out_last", out_last_n, 0);
      chk("rst_out_idx", out_idx_n, 0);
      chk("rst_err_cnt", err_cnt_n, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // single symbol, out_ready high
      s_out = n_out; s_last = n_last; s_br = br_log.size();
      for (int i = 0; i < N; i++) begin
         send(i, N - 1 - i);
         if (i == N - 2) chk("valid_before_64", out_valid_n, 0);
         if (i == N - 1) begin
            chk("valid_after_64", out_valid_n, 1);
            chk("first_idx", out_idx_n, 0);
            chk("first_re", out_re_n, 0);
         end
      end
      wait_drain();
      chk("single_outs", n_out - s_out, 64);
      chk("single_lasts", n_last - s_last, 1);
      chk("single_err_cnt", err_cnt_n, 0);
      chk("br_idx0", br_log[s_br], 0);
      chk("br_idx1", br_log[s_br + 1], 32);
      chk("br_idx2", br_log[s_br + 2], 16);
      chk("br_idx3", br_log[s_br + 3], 48);

      // sequence error on sample 5
      s_pulse = n_pulse;
      send_sym(5, 9);
      wait_drain();
      chk("seq_pulses", n_pulse - s_pulse, 1);
      chk("seq_err_cnt", err_cnt_n, 1);
      chk("seq_re_idx5", cap_re[5], 9);
      chk("seq_re_idx6", cap_re[6], 6);

      // back-pressure: two symbols with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 2 * N; i++) begin
         send(i % N, N - 1 - (i % N));
         if (i == 2 * N - 2) chk("bp_ready_127", in_ready_n, 1);
      end
      chk("bp_ready_128", in_ready_n, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid_n, 1);
         chk("bp_hold_re", out_re_n, 0);
         chk("bp_hold_im", out_im_n, 63);
         chk("bp_hold_idx", out_idx_n, 0);
         chk("bp_hold_ready", in_ready_n, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();

      // reset after 40 samples
      for (int i = 0; i < 40; i++) send(i, N - 1 - i);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid_n, 0);
      chk("mid_rst_ready", in_ready_n, 1);
      chk("mid_rst_err_cnt", err_cnt_n, 0);
      chk("mid_rst_idx", out_idx_n, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      s_idx = idx_log.size();
      send_sym(-1, 0);
      wait_drain();
      chk("post_rst_outs", idx_log.size() - s_idx, 64);
      chk("post_rst_idx0", idx_log[s_idx], 0);
      chk("post_rst_re0", re_log[s_idx], 0);
      chk("post_rst_err_cnt", err_cnt_n, 0);

      // streaming: 10 back-to-back symbols
      s_out = n_out; s_last = n_last; s_low = n_rdy_low;
      for (int s = 0; s < 10; s++) send_sym(-1, 0);
      wait_drain();
      chk("stream_ready_low", n_rdy_low - s_low, 0);
      chk("stream_outs", n_out - s_out, 640);
      chk("stream_lasts", n_last - s_last, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/symbol_pingpong_buffer.md
SYMBOL_PINGPONG_BUFFER -- requirements
Module: symbol_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each real/imag sample component.
REQ-002 SHALL have parameter N_SUB, default 64, samples per OFDM symbol; fixed at a power of two.
REQ-003 SHALL have parameter BIT_REVERSE, default 0; 1 = read out in bit-reversed index order.
REQ-004 SHALL have parameter CHECK_SEQ, default 1; 1 = check the incoming index-pattern stream.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  input sample valid.
REQ-008 SHALL have port in_ready  output  1  buffer can accept a sample.
REQ-009 SHALL have ports in_re and in_im  input  DATA_W each  input sample real/imag.
REQ-010 SHALL have port out_valid  output  1  output sample valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a sample.
REQ-012 SHALL have ports out_re and out_im  output  DATA_W each  output sample real/imag.
REQ-013 SHALL have port out_idx  output  log2(N_SUB)  subcarrier index of the current output.
REQ-014 SHALL have port out_last  output  1  high with the final sample of a symbol.
REQ-015 SHALL have port err_seq  output  1  one-cycle pulse on a sequence mismatch.
REQ-016 SHALL have port err_cnt  output  8  saturating count of mismatches.

Function
REQ-017 SHALL hold two banks of N_SUB entries with a full flag per bank, a write-bank select and a read-bank select.
REQ-018 SHALL accept a sample on an edge where in_valid and in_ready are both high; it is written at the write pointer of the write bank, and the write pointer then increments.
REQ-019 SHALL, on accepting write index N_SUB-1, set full[write bank], toggle the write-bank select and wrap the write pointer to 0.
REQ-020 SHALL drive in_ready = !full[write bank], combinationally from registered state.
REQ-021 SHALL drive out_valid = full[read bank]; out_valid first rises in the cycle after the edge that accepts the 64th sample (one-cycle latency).
REQ-022 SHALL drive out_re/out_im from the read bank at address out_idx; out_idx = read pointer, or the read pointer bit-reversed when BIT_REVERSE=1.
REQ-023 SHALL advance the read pointer when out_valid and out_ready are both high; out_last = out_valid and (read pointer == N_SUB-1).
REQ-024 SHALL, when the last sample is accepted, clear full[read bank], toggle the read-bank select and wrap the read pointer to 0.
REQ-025 SHALL hold out_re, out_im, out_idx and out_last stable while out_valid is high and out_ready is low.
REQ-026 SHALL let a write-side fill and a read-side drain in the same edge both take effect; set and clear always target different banks.
REQ-027 SHALL sustain 1 sample/cycle continuously when out_ready is held high; in_ready never drops in that case.
REQ-028 SHALL, when CHECK_SEQ=1 and a sample is accepted with in_re != write pointer or in_im != (N_SUB-1 - write pointer), pulse err_seq on the next cycle and increment err_cnt, saturating at 255.
REQ-029 SHALL store a mismatched sample normally; checking never stalls the data path.
REQ-030 SHALL tie err_seq and err_cnt to 0 when CHECK_SEQ=0.

Reset
REQ-031 SHALL, while reset is low, asynchronously clear both full flags, both bank selects, both pointers, err_seq and err_cnt.
REQ-032 SHALL give these output values during reset: in_ready=1, out_valid=0, out_last=0, out_idx=0.
REQ-033 SHALL leave bank storage contents unreset; an asserted reset mid-symbol discards any partial or full banks.

Structure
REQ-034 SHALL place the N_SUB default, the index width constant and the bit-reverse function in the shared OFDM package.
REQ-035 SHALL instantiate one sub-module, sym_bank_ram: a single N_SUB x 2*DATA_W register array with one write port and an asynchronous read port, instantiated twice.

Verification
REQ-036 SHALL cover single symbol: feed re=0..63, im=63..0 with out_ready=1 -> out_valid rises on cycle 65; outputs match in order; out_last on idx 63; err_cnt=0.
REQ-037 SHALL cover back-pressure: out_ready=0 while 128 samples are fed -> in_ready falls after sample 128; the first output holds re=0, im=63 stable.
REQ-038 SHALL cover bit-reverse: BIT_REVERSE=1, one symbol -> out_idx sequence starts 0,32,16,48; out_re equals out_idx.
REQ-039 SHALL cover sequence error: sample 5 sent with re=9 -> a single err_seq pulse, err_cnt=1, and out_re at idx 5 = 9.
REQ-040 SHALL cover reset mid-operation: reset asserted after 40 samples -> immediately out_valid=0, in_ready=1, err_cnt=0; the next symbol starts at index 0.
REQ-041 SHALL cover streaming: 10 back-to-back symbols with out_ready=1 -> in_ready is never low, and exactly 640 outputs with 10 out_last pulses.
